truth_table_sequencer: RTL and testbench

- Stimulus-and-capture stage placed directly upstream of a small combinational logic function (e.g. the 2-input gate network f(x,y)).
- Drives every input combination in ascending binary order onto the function's inputs.
- Waits a programmable settle time per vector, samples the function's output, and assembles a 2^N-bit truth-table word.
- Replaces hand-written for-loop testbenches with a reusable synthesizable sequencer and start/done handshake.

---
 rtl/truth_table_sequencer_if.sv | 36 +++
 rtl/truth_table_sequencer.sv | 102 ++++++++++
 tb/tb_truth_table_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its user: start/done handshake, function drive/sense.
// Optional TT_EXPECT_CHECK_EN adds the expected-table input and the mismatch flag.
interface truth_table_sequencer_if #(
  parameter int unsigned N_INPUTS = 2
) ();
  localparam int unsigned Width = 1 << N_INPUTS;

  logic                start;
  logic                s_in;
  logic [N_INPUTS-1:0] x_out;
  logic                busy;
  logic                done;
  logic [Width-1:0]    table_out;
`ifdef TT_EXPECT_CHECK_EN
  logic [Width-1:0]    expected;
  logic                mismatch;

  modport slave (
    input  start, s_in, expected,
    output x_out, busy, done, table_out, mismatch
  );
  modport master (
    output start, s_in, expected,
    input  x_out, busy, done, table_out, mismatch
  );
`else
  modport slave (
    input  start, s_in,
    output x_out, busy, done, table_out
  );
  modport master (
    output start, s_in,
    input  x_out, busy, done, table_out
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps all 2^N_INPUTS input vectors in ascending order, holds each for SETTLE_CYCLES, then
// samples s_in into table_out. Optional TT_EXPECT_CHECK_EN compares the result to a reference.
module truth_table_sequencer #(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sequencer_if.slave bus
);
  localparam int unsigned Width = 1 << N_INPUTS;
  localparam int unsigned IdxW  = N_INPUTS + 1;
  localparam int unsigned CntW  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] table_q, table_d;
`ifdef TT_EXPECT_CHECK_EN
  logic [Width-1:0] expected_q, expected_d;
  logic             mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    table_d = table_q;
`ifdef TT_EXPECT_CHECK_EN
    expected_d = expected_q;
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          index_d = '0;
          cnt_d   = '0;
          table_d = '0;
          state_d = StSettle;
`ifdef TT_EXPECT_CHECK_EN
          expected_d = bus.expected;
          mismatch_d = 1'b0;
`endif
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) state_d = StSample;
      end
      StSample: begin
        table_d[index_q[N_INPUTS-1:0]] = bus.s_in;
        if (index_q == IdxW'(Width - 1)) begin
          state_d = StDone;
        end else begin
          // x_out only moves here, so every vector gets the full settle window
          index_d = index_q + 1'b1;
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef TT_EXPECT_CHECK_EN
        mismatch_d = (table_q != expected_q);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      cnt_q   <= '0;
      table_q <= '0;
`ifdef TT_EXPECT_CHECK_EN
      expected_q <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
`ifdef TT_EXPECT_CHECK_EN
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign bus.x_out     = index_q[N_INPUTS-1:0];
  assign bus.busy      = (state_q == StSettle) || (state_q == StSample);
  assign bus.done      = (state_q == StDone);
  assign bus.table_out = table_q;
`ifdef TT_EXPECT_CHECK_EN
  assign bus.mismatch  = mismatch_q;
`endif
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (settle 1 and 3) share start and the function under test.
// Stimulus pushes expected sweeps; a monitor checks x_out, busy, done timing and the table.
module tb_truth_table_sequencer;
  localparam int unsigned N  = 2;
  localparam int unsigned W  = 1 << N;
  localparam int unsigned SA = 1;
  localparam int unsigned SB = 3;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] func  = '0;
  logic [W-1:0] expv  = '0;
  int           cyc   = 0;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sequencer_if #(.N_INPUTS(N)) if_a ();
  truth_table_sequencer_if #(.N_INPUTS(N)) if_b ();

  assign if_a.start = start;
  assign if_b.start = start;
  assign if_a.s_in  = func[if_a.x_out];
  assign if_b.s_in  = func[if_b.x_out];
`ifdef TT_EXPECT_CHECK_EN
  assign if_a.expected = expv;
  assign if_b.expected = expv;
`endif

  truth_table_sequencer #(.N_INPUTS(N), .SETTLE_CYCLES(SA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );
  truth_table_sequencer #(.N_INPUTS(N), .SETTLE_CYCLES(SB)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  typedef struct {
    logic [W-1:0] tbl;
    logic [W-1:0] exp;
    int           c0;
  } txn_t;

  txn_t q[2][$];
  logic pend_mis[2];
  logic mis_exp[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [N-1:0] xo;
        logic         bz, dn, mis;
        logic [W-1:0] tout;
        int           s, k, len;
        txn_t         t;
        xo   = (i == 1) ? if_b.x_out : if_a.x_out;
        bz   = (i == 1) ? if_b.busy : if_a.busy;
        dn   = (i == 1) ? if_b.done : if_a.done;
        tout = (i == 1) ? if_b.table_out : if_a.table_out;
`ifdef TT_EXPECT_CHECK_EN
        mis  = (i == 1) ? if_b.mismatch : if_a.mismatch;
`else
        mis  = 1'b0;
`endif
        s    = (i == 1) ? SB : SA;
        len  = W * (s + 1);
        if (q[i].size() > 0) begin
          k = cyc - q[i][0].c0;
          if (k < len) begin
            check($sformatf("x_out[%0d]", i), 32'(xo), 32'(k / (s + 1)));
            check($sformatf("busy[%0d]", i), 32'(bz), 32'd1);
            if (k == 0) begin
              check($sformatf("table_cleared[%0d]", i), 32'(tout), 32'd0);
`ifdef TT_EXPECT_CHECK_EN
              check($sformatf("mismatch_cleared[%0d]", i), 32'(mis), 32'd0);
`endif
            end
          end
        end
        if (pend_mis[i] && !dn) begin
          pend_mis[i] = 1'b0;
`ifdef TT_EXPECT_CHECK_EN
          check($sformatf("mismatch[%0d]", i), 32'(mis), 32'(mis_exp[i]));
`endif
        end
        if (dn) begin
          check($sformatf("done_expected[%0d]", i), 32'(q[i].size() > 0), 32'd1);
          if (q[i].size() > 0) begin
            t = q[i].pop_front();
            check($sformatf("done_latency[%0d]", i), 32'(cyc - t.c0 + 1), 32'(len + 1));
            check($sformatf("table_out[%0d]", i), 32'(tout), 32'(t.tbl));
            check($sformatf("busy_in_done[%0d]", i), 32'(bz), 32'd0);
            pend_mis[i] = 1'b1;
            mis_exp[i]  = (t.tbl != t.exp);
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] ref_func();
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) begin
      logic x, y;
      x    = (k >> 1) & 1;
      y    = k & 1;
      r[k] = (y & ~x) & ~(~y | x);
    end
    return r;
  endfunction

  task automatic issue_start();
    txn_t t;
    @(negedge clk);
    start = 1'b1;
    t.tbl = func;
    t.exp = expv;
    t.c0  = cyc + 1;
    q[0].push_back(t);
    q[1].push_back(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sweep_timeout", 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(input logic [W-1:0] f, input logic [W-1:0] e, input bit extra);
    func = f;
    expv = e;
    issue_start();
    if (extra) begin
      // pulses land on the edges two and five after acceptance
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    pend_mis[0] = 1'b0; pend_mis[1] = 1'b0;
    mis_exp[0]  = 1'b0; mis_exp[1]  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(if_a.busy | if_b.busy), 32'd0);
    check("rst_done", 32'(if_a.done | if_b.done), 32'd0);
    check("rst_table", 32'(if_a.table_out | if_b.table_out), 32'd0);
    check("rst_x_out", 32'(if_a.x_out | if_b.x_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    sweep(ref_func(), 4'b0010, 1'b0);
    sweep(ref_func(), 4'b0100, 1'b0);
    sweep(4'b0110, 4'b0110, 1'b1);
    sweep(4'b1111, 4'b0000, 1'b0);
    sweep(4'b1111, 4'b1111, 1'b0);

    // reset abandons a sweep; any later done is flagged by the monitor
    func = 4'b1011;
    issue_start();
    @(negedge clk);
    rst = 1'b1;
    q[0].delete(); q[1].delete();
    pend_mis[0] = 1'b0; pend_mis[1] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(if_a.busy | if_b.busy), 32'd0);
    check("midrst_x_out", 32'(if_a.x_out | if_b.x_out), 32'd0);
    check("midrst_table", 32'(if_a.table_out | if_b.table_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // start coincident with reset is ignored
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("start_with_rst", 32'(if_a.busy | if_b.busy), 32'd0);
    @(negedge clk);

    for (int it = 0; it < 8; it++) begin
      logic [W-1:0] f;
      f = W'($urandom);
      sweep(f, ($urandom_range(1) == 1) ? f : W'($urandom), bit'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
